// File: rtl/pic_pkg.sv
// Shared constants for the 8259-lite interrupt controller: OCW command
// encodings and the default vector base.
package pic_pkg;
    localparam logic [7:0] EOI_NS          = 8'h20;
    localparam logic [4:0] EOI_SPEC        = 5'b01100;
    localparam logic [7:0] OCW3_IRR        = 8'h0A;
    localparam logic [7:0] OCW3_ISR        = 8'h0B;
    localparam logic [7:0] DEF_VECTOR_BASE = 8'h08;
endpackage

// File: rtl/pic_prio_enc.sv
// Combinational 8-bit priority encoder; the lowest set index wins and
// vld_o flags a non-empty input.
module pic_prio_enc (
    input  logic [7:0] req_i,
    output logic [2:0] idx_o,
    output logic       vld_o
);
    always_comb begin
        idx_o = 3'd0;
        vld_o = 1'b0;
        // Scan downward so the last hit, the lowest index, is kept.
        for (int i = 7; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = 3'(i);
                vld_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_pic8259_lite.sv
// Wishbone I/O-mapped 8259A-subset interrupt controller: edge-triggered IRR,
// IMR masking, ISR nesting with EOI, and a registered INTA vector.
import pic_pkg::*;

module wb_pic8259_lite #(
    parameter logic [7:0] VECTOR_BASE = DEF_VECTOR_BASE,
    parameter logic [7:0] IMR_RESET   = 8'h00
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic [7:0]  irq_i,
    input  logic        inta_i,
    output logic        intr_o,
    output logic [7:0]  vec_o
);
    logic [7:0]  irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
    logic [7:0]  irq_d_q, vec_q, vec_d;
    logic        inta_d_q, rdsel_q, rdsel_d, ack_q, intr_q, intr_d;
    logic [15:0] dat_q, dat_d;

    logic [7:0]  rise, pend, isr_eoi, upto_p, d;
    logic [2:0]  pend_idx, isr_idx;
    logic        pend_v, isr_v, inta_r, req, wr, grant;

    pic_prio_enc u_pend_enc (.req_i(pend),  .idx_o(pend_idx), .vld_o(pend_v));
    pic_prio_enc u_isr_enc  (.req_i(isr_q), .idx_o(isr_idx),  .vld_o(isr_v));

    always_comb begin
        rise    = irq_i & ~irq_d_q;
        inta_r  = inta_i & ~inta_d_q;
        req     = wb_stb_i & wb_cyc_i & ~ack_q;
        wr      = req & wb_we_i;
        d       = wb_dat_i[7:0];
        pend    = irr_q & ~imr_q;
        // Bits 0..p: any in-service bit here blocks the pending request.
        upto_p  = ~(8'hFE << pend_idx);

        isr_eoi = isr_q;
        rdsel_d = rdsel_q;
        imr_d   = imr_q;
        if (wr && wb_sel_i[0]) begin
            if (d == EOI_NS && isr_v) isr_eoi[isr_idx] = 1'b0;
            if (d[7:3] == EOI_SPEC)   isr_eoi[d[2:0]] = 1'b0;
            if (d == OCW3_IRR)        rdsel_d = 1'b0;
            if (d == OCW3_ISR)        rdsel_d = 1'b1;
        end
        if (wr && wb_sel_i[1]) imr_d = wb_dat_i[15:8];

        // INTA sees the post-EOI ISR but the pre-write IMR.
        grant = inta_r && pend_v && ((isr_eoi & upto_p) == 8'h00);

        irr_d = irr_q;
        isr_d = isr_eoi;
        if (grant) begin
            irr_d[pend_idx] = 1'b0;
            isr_d[pend_idx] = 1'b1;
        end
        irr_d  = irr_d | rise;
        intr_d = grant ? 1'b0 : (pend_v && ((isr_q & upto_p) == 8'h00));

        vec_d = vec_q;
        if (inta_r) vec_d = {VECTOR_BASE[7:3], grant ? pend_idx : 3'd7};

        dat_d = dat_q;
        if (req && !wb_we_i) dat_d = {imr_q, rdsel_q ? isr_q : irr_q};
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irr_q    <= 8'h00;
            isr_q    <= 8'h00;
            imr_q    <= IMR_RESET;
            irq_d_q  <= 8'h00;
            inta_d_q <= 1'b0;
            rdsel_q  <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= 16'h0000;
            intr_q   <= 1'b0;
            vec_q    <= {VECTOR_BASE[7:3], 3'd7};
        end else begin
            irr_q    <= irr_d;
            isr_q    <= isr_d;
            imr_q    <= imr_d;
            irq_d_q  <= irq_i;
            inta_d_q <= inta_i;
            rdsel_q  <= rdsel_d;
            ack_q    <= req;
            dat_q    <= dat_d;
            intr_q   <= intr_d;
            vec_q    <= vec_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign intr_o   = intr_q;
    assign vec_o    = vec_q;
endmodule

// File: tb/tb_wb_pic8259_lite.sv
// Self-checking bench for wb_pic8259_lite: vector table, directed corner
// sequences and random traffic against a behavioural model.
module tb_wb_pic8259_lite;
    logic        wb_clk_i, wb_rst_i;
    logic [15:0] wb_dat_i, wb_dat_o;
    logic [1:0]  wb_sel_i;
    logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
    logic [7:0]  irq_i, vec_o;
    logic        inta_i, intr_o;

    int checks = 0;
    int errors = 0;

    wb_pic8259_lite #(.VECTOR_BASE(8'h08), .IMR_RESET(8'h00)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
        .irq_i(irq_i), .inta_i(inta_i), .intr_o(intr_o), .vec_o(vec_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Behavioural model state
    logic [7:0]  m_irr, m_isr, m_imr, m_irqd, m_vec;
    logic        m_rdsel, m_intad, m_ack, m_intr, m_rdack;
    logic [15:0] m_dat;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00; m_irqd = 8'h00;
        m_vec = 8'h0F; m_rdsel = 1'b0; m_intad = 1'b0; m_ack = 1'b0;
        m_intr = 1'b0; m_rdack = 1'b0; m_dat = 16'h0000;
    endtask

    // One clock: model predicts from current inputs, DUT checked after edge.
    task automatic tick();
        logic [7:0] n_irr, n_isr, n_imr, n_vec, dd;
        logic       n_rdsel, ir, req, g, n_intr;
        int         p, s;
        ir  = inta_i & ~m_intad;
        req = wb_stb_i & wb_cyc_i & ~m_ack;
        p   = lowest(m_irr & ~m_imr);
        s   = lowest(m_isr);
        n_isr = m_isr; n_imr = m_imr; n_rdsel = m_rdsel;
        dd = wb_dat_i[7:0];
        if (req && wb_we_i && wb_sel_i[0]) begin
            if (dd == 8'h20 && s < 8) n_isr[3'(s)] = 1'b0;
            if (dd[7:3] == 5'b01100)  n_isr[dd[2:0]] = 1'b0;
            if (dd == 8'h0A) n_rdsel = 1'b0;
            if (dd == 8'h0B) n_rdsel = 1'b1;
        end
        if (req && wb_we_i && wb_sel_i[1]) n_imr = wb_dat_i[15:8];
        g = ir && (p < 8) && (p < lowest(n_isr));
        n_irr = m_irr;
        if (g) begin
            n_irr[3'(p)] = 1'b0;
            n_isr[3'(p)] = 1'b1;
        end
        n_irr  = n_irr | (irq_i & ~m_irqd);
        n_intr = g ? 1'b0 : ((p < 8) && (p < s));
        n_vec  = m_vec;
        if (ir) n_vec = g ? (8'h08 + 8'(p)) : 8'h0F;
        m_rdack = req && !wb_we_i;
        if (m_rdack) m_dat = {m_imr, m_rdsel ? m_isr : m_irr};
        @(posedge wb_clk_i);
        #1;
        m_irr = n_irr; m_isr = n_isr; m_imr = n_imr; m_rdsel = n_rdsel;
        m_irqd = irq_i; m_intad = inta_i; m_ack = req; m_intr = n_intr; m_vec = n_vec;
        chk("model_intr", {15'd0, intr_o}, {15'd0, m_intr});
        chk("model_vec", {8'd0, vec_o}, {8'd0, m_vec});
        chk("model_ack", {15'd0, wb_ack_o}, {15'd0, m_ack});
        if (m_rdack) chk("model_dat", wb_dat_o, m_dat);
    endtask

    task automatic bus_idle();
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        wb_sel_i = 2'b00; wb_dat_i = 16'h0000;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [15:0] dat);
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = sel; wb_dat_i = dat;
        tick();
        bus_idle();
        tick();
    endtask

    task automatic rd(input string name, input logic [15:0] exp);
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 2'b11;
        tick();
        chk(name, wb_dat_o, exp);
        bus_idle();
        tick();
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        irq_i = m; tick();
        irq_i = 8'h00; tick();
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        #1;
        model_reset();
        chk("rst_intr", {15'd0, intr_o}, 16'h0000);
        chk("rst_vec", {8'd0, vec_o}, 16'h000F);
        chk("rst_ack", {15'd0, wb_ack_o}, 16'h0000);
        chk("rst_dat", wb_dat_o, 16'h0000);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  irq;
        logic        inta, stb, we;
        logic [1:0]  sel;
        logic [15:0] dat;
        logic        e_intr;
        logic [7:0]  e_vec;
        logic        e_ack, e_rd;
        logic [15:0] e_dat;
    } vec_t;
    vec_t tbl[17];

    initial begin
        bus_idle();
        irq_i = 8'h00; inta_i = 1'b0; wb_rst_i = 1'b1;
        model_reset();

        // Basic IRQ0 grant, OCW3 select, EOI and IRQ1 grant
        tbl[0]  = '{8'h01, 0, 0, 0, 2'b00, 16'h0000, 0, 8'h0F, 0, 0, 16'h0000};
        tbl[1]  = '{8'h00, 0, 0, 0, 2'b00, 16'h0000, 1, 8'h0F, 0, 0, 16'h0000};
        tbl[2]  = '{8'h00, 1, 0, 0, 2'b00, 16'h0000, 0, 8'h08, 0, 0, 16'h0000};
        tbl[3]  = '{8'h00, 1, 0, 0, 2'b00, 16'h0000, 0, 8'h08, 0, 0, 16'h0000};
        tbl[4]  = '{8'h00, 0, 1, 0, 2'b11, 16'h0000, 0, 8'h08, 1, 1, 16'h0000};
        tbl[5]  = '{8'h00, 0, 0, 0, 2'b00, 16'h0000, 0, 8'h08, 0, 0, 16'h0000};
        tbl[6]  = '{8'h00, 0, 1, 1, 2'b01, 16'h000B, 0, 8'h08, 1, 0, 16'h0000};
        tbl[7]  = '{8'h00, 0, 0, 0, 2'b00, 16'h0000, 0, 8'h08, 0, 0, 16'h0000};
        tbl[8]  = '{8'h00, 0, 1, 0, 2'b11, 16'h0000, 0, 8'h08, 1, 1, 16'h0001};
        tbl[9]  = '{8'h00, 0, 0, 0, 2'b00, 16'h0000, 0, 8'h08, 0, 0, 16'h0000};
        tbl[10] = '{8'h02, 0, 0, 0, 2'b00, 16'h0000, 0, 8'h08, 0, 0, 16'h0000};
        tbl[11] = '{8'h00, 0, 0, 0, 2'b00, 16'h0000, 0, 8'h08, 0, 0, 16'h0000};
        tbl[12] = '{8'h00, 0, 1, 1, 2'b01, 16'h0020, 0, 8'h08, 1, 0, 16'h0000};
        tbl[13] = '{8'h00, 0, 0, 0, 2'b00, 16'h0000, 1, 8'h08, 0, 0, 16'h0000};
        tbl[14] = '{8'h00, 1, 0, 0, 2'b00, 16'h0000, 0, 8'h09, 0, 0, 16'h0000};
        tbl[15] = '{8'h00, 0, 1, 0, 2'b11, 16'h0000, 0, 8'h09, 1, 1, 16'h0002};
        tbl[16] = '{8'h00, 0, 0, 0, 2'b00, 16'h0000, 0, 8'h09, 0, 0, 16'h0000};

        #12;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            irq_i = tbl[i].irq; inta_i = tbl[i].inta;
            wb_stb_i = tbl[i].stb; wb_cyc_i = tbl[i].stb; wb_we_i = tbl[i].we;
            wb_sel_i = tbl[i].sel; wb_dat_i = tbl[i].dat;
            tick();
            chk($sformatf("tbl%0d_intr", i), {15'd0, intr_o}, {15'd0, tbl[i].e_intr});
            chk($sformatf("tbl%0d_vec", i), {8'd0, vec_o}, {8'd0, tbl[i].e_vec});
            chk($sformatf("tbl%0d_ack", i), {15'd0, wb_ack_o}, {15'd0, tbl[i].e_ack});
            if (tbl[i].e_rd) chk($sformatf("tbl%0d_dat", i), wb_dat_o, tbl[i].e_dat);
        end
        bus_idle(); irq_i = 8'h00; inta_i = 1'b0;

        // Nested: IRQ1 preempts IRQ4 in service
        do_reset();
        pulse_irq(8'h10);
        inta_i = 1'b1; tick(); chk("nest_vec4", {8'd0, vec_o}, 16'h000C);
        inta_i = 1'b0; tick();
        pulse_irq(8'h02);
        chk("nest_intr", {15'd0, intr_o}, 16'h0001);
        inta_i = 1'b1; tick(); chk("nest_vec1", {8'd0, vec_o}, 16'h0009);
        inta_i = 1'b0; tick();
        wr(2'b01, 16'h000B);
        rd("nest_isr", 16'h0012);
        wr(2'b01, 16'h0020);
        rd("nest_eoi", 16'h0010);

        // Masking
        do_reset();
        wr(2'b10, 16'hFE00);
        pulse_irq(8'h02);
        chk("mask_intr0", {15'd0, intr_o}, 16'h0000);
        wr(2'b01, 16'h000A);
        rd("mask_irr", 16'hFE02);
        wr(2'b10, 16'h0000);
        chk("mask_intr1", {15'd0, intr_o}, 16'h0001);

        // Spurious INTA and back-to-back reads
        do_reset();
        inta_i = 1'b1; tick(); chk("spur_vec", {8'd0, vec_o}, 16'h000F);
        inta_i = 1'b0; tick();
        wr(2'b01, 16'h000B);
        rd("spur_isr", 16'h0000);
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("b2b_ack%0d", i), {15'd0, wb_ack_o}, {15'd0, (i % 2 == 0)});
        end
        bus_idle(); tick();

        // Held level sets IRR once
        do_reset();
        irq_i = 8'h04; tick(); tick();
        chk("held_intr", {15'd0, intr_o}, 16'h0001);
        inta_i = 1'b1; tick(); chk("held_vec", {8'd0, vec_o}, 16'h000A);
        inta_i = 1'b0; tick(); tick(); tick();
        chk("held_nointr", {15'd0, intr_o}, 16'h0000);
        rd("held_irr0", 16'h0000);
        irq_i = 8'h00; tick();
        irq_i = 8'h04; tick();
        irq_i = 8'h00; tick();
        rd("held_irr1", 16'h0004);

        // Reset in the middle of INTA
        do_reset();
        pulse_irq(8'h08);
        inta_i = 1'b1; tick(); chk("mid_vec", {8'd0, vec_o}, 16'h000B);
        do_reset();
        tick(); chk("mid_spur", {8'd0, vec_o}, 16'h000F);
        inta_i = 1'b0; tick();
        rd("mid_irr", 16'h0000);
        wr(2'b01, 16'h000B);
        rd("mid_isr", 16'h0000);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) irq_i = irq_i ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) inta_i = ~inta_i;
            if ($urandom_range(0, 2) == 0) begin
                wb_stb_i = 1'b1;
                wb_cyc_i = ($urandom_range(0, 7) != 0);
                wb_we_i  = $urandom_range(0, 1) == 1;
                wb_sel_i = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 4))
                    0: wb_dat_i[7:0] = 8'h20;
                    1: wb_dat_i[7:0] = 8'h60 + 8'($urandom_range(0, 7));
                    2: wb_dat_i[7:0] = 8'h0A;
                    3: wb_dat_i[7:0] = 8'h0B;
                    default: wb_dat_i[7:0] = 8'($urandom);
                endcase
                wb_dat_i[15:8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            end else begin
                bus_idle();
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
